avl_mm_bridge: RTL and testbench
================================

// Module: avl_mm_bridge
// PURPOSE
// - Parametrised CPU-to-Avalon-MM master bridge; successor to the fixed 28/32-bit memory interface.
// - Sits between the RV32I core load/store port and the SDRAM/on-chip Avalon slave.
// - Adds a req/ack CPU handshake, byte enables, misalignment rejection and variable read latency.
// - Adds an explicit write-complete pulse. Exactly one transaction is in flight at a time.
// PARAMETERS
// ADDR_W      28    byte address width, CPU and Avalon sides
// DATA_W      32    data width; power of 2, >= 8
// BE_W        DATA_W/8  byte-enable width; derived, not overridable
// TIMEOUT_CYC 1024  watchdog limit in cycles (used only with AVL_TIMEOUT_EN)
// PORTS
// iCLK               in   1       clock; all logic on rising edge
// iRST               in   1       synchronous, active-high reset
// cpu_req            in   1       request valid; hold stable until cpu_ack
// cpu_we             in   1       1 = write, 0 = read
// cpu_addr           in   ADDR_W  byte address
// cpu_be             in   BE_W    byte enables
// cpu_wdata          in   DATA_W  write data
// cpu_ack            out  1       1-cycle pulse: request accepted (captured)
// cpu_rdata          out  DATA_W  read data; valid while cpu_rvalid=1
// cpu_rvalid         out  1       1-cycle pulse: read data returned
// cpu_wdone          out  1       1-cycle pulse: write accepted by slave
// cpu_err            out  1       1-cycle pulse: request rejected or aborted
// busy               out  1       1 while state != IDLE
// avl_address        out  ADDR_W  Avalon byte address
// avl_read           out  1       Avalon read strobe
// avl_write          out  1       Avalon write strobe
// avl_writedata      out  DATA_W  Avalon write data
// avl_byteenable     out  BE_W    Avalon byte enables
// avl_waitrequest    in   1       slave stall
// avl_readdata       in   DATA_W  slave read data
// avl_readdatavalid  in   1       slave read data strobe
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0, including avl_address, avl_writedata,
//   avl_byteenable and cpu_rdata. Reset mid-transaction drops avl_read/avl_write
//   on the next edge; no response pulse is generated.
// - FSM states: IDLE, WR, RD, RD_WAIT.
// - IDLE, on cpu_req=1:
//   - Misaligned: cpu_addr[log2(BE_W)-1:0] != 0, or cpu_be == 0.
//     Pulse cpu_ack and cpu_err on the next cycle; no Avalon cycle; stay IDLE.
//   - Otherwise: capture addr/be/wdata into the Avalon regs; pulse cpu_ack.
//     Next state is WR if cpu_we=1, else RD.
// - Avalon strobes are registered: asserted the cycle after acceptance (latency 1).
// - WR: avl_write=1; all Avalon outputs held while avl_waitrequest=1.
//   On the first edge with avl_waitrequest=0: drop avl_write, pulse cpu_wdone, go to IDLE.
// - RD: avl_read=1, held during waitrequest. On an edge with waitrequest=0:
//   - readdatavalid also 1 (zero-latency slave): cpu_rdata<=readdata, pulse cpu_rvalid, go to IDLE.
//   - otherwise: drop avl_read and go to RD_WAIT.
// - RD_WAIT: wait any number of cycles; on readdatavalid=1 latch data, pulse cpu_rvalid, go to IDLE.
// - Stray avl_readdatavalid in IDLE/WR is ignored; cpu_rdata is unchanged.
// - cpu_rdata holds its last value until the next read completes.
// - cpu_req high in the same cycle a response pulses: not sampled until the state is IDLE
//   (earliest acceptance is the cycle after returning to IDLE, so back-to-back ops are >= 3 cycles apart).
// - Never avl_read and avl_write asserted together.
// CONFIGURATION
// - AVL_TIMEOUT_EN defined:
//   - Counter clears on entry to WR/RD and increments each cycle in WR/RD/RD_WAIT.
//   - On reaching TIMEOUT_CYC-1: drop strobes, pulse cpu_err (no wdone/rvalid), go to IDLE.
//   - A late readdatavalid after abort is ignored.
// - AVL_TIMEOUT_EN undefined: no counter logic; the bridge waits indefinitely; cpu_err only signals misalignment.
// TESTING
// - Write addr=0x10, be=4'hF, data=0xDEADBEEF, waitrequest=0 -> ack cycle 1;
//   avl_write=1 cycle 2 with same addr/data; cpu_wdone cycle 3.
// - Same write with waitrequest high for 5 cycles -> avl_write and all Avalon outputs held
//   for exactly 6 cycles; a single cpu_wdone pulse.
// - Read addr=0x20, readdatavalid 7 cycles after the strobe, data=0x12345678 ->
//   avl_read high 1 cycle; cpu_rvalid once; cpu_rdata=0x12345678.
// - Read addr=0x22 (misaligned), or be=0 -> cpu_ack+cpu_err the next cycle;
//   avl_read/avl_write never asserted.
// - Assert iRST during RD_WAIT -> next cycle all outputs 0, busy=0;
//   a subsequent readdatavalid produces no cpu_rvalid.
// - AVL_TIMEOUT_EN, TIMEOUT_CYC=16, slave never responds -> cpu_err 16 cycles after
//   strobe assertion; busy=0 afterwards.

Source files
------------

// File: rtl/avl_mm_bridge_if.sv
// CPU load/store port and Avalon-MM master signals of avl_mm_bridge, bundled.
// master = bridge view; slave = the CPU core plus Avalon slave surrounding it.
interface avl_mm_bridge_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [BE_W-1:0]   cpu_be;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_wdone;
  logic              cpu_err;
  logic              busy;
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read;
  logic              avl_write;
  logic [DATA_W-1:0] avl_writedata;
  logic [BE_W-1:0]   avl_byteenable;
  logic              avl_waitrequest;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdatavalid;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
           avl_waitrequest, avl_readdata, avl_readdatavalid,
    output cpu_ack, cpu_rdata, cpu_rvalid, cpu_wdone, cpu_err, busy,
           avl_address, avl_read, avl_write, avl_writedata, avl_byteenable
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
           avl_waitrequest, avl_readdata, avl_readdatavalid,
    input  cpu_ack, cpu_rdata, cpu_rvalid, cpu_wdone, cpu_err, busy,
           avl_address, avl_read, avl_write, avl_writedata, avl_byteenable
  );
endinterface

// File: rtl/avl_mm_bridge.sv
// CPU req/ack to Avalon-MM master bridge, one transaction in flight, registered strobes.
// Optional watchdog abort enabled by defining AVL_TIMEOUT_EN (limit TIMEOUT_CYC).
module avl_mm_bridge #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            iCLK,
  input  logic            iRST,
  avl_mm_bridge_if.master bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  state_t            state, state_next;
  logic              ack_q, err_q, wdone_q, rvalid_q, write_q, read_q;
  logic              ack_d, err_d, wdone_d, rvalid_d, write_d, read_d, load;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [BE_W-1:0]   be_q;
  logic              accept, bad_req, wr_done, rd_release, rd_done, timeout;

  // ack_q blocks re-sampling a request still held high during its own ack cycle
  assign accept     = (state == IDLE) && bus.cpu_req && !ack_q;
  assign bad_req    = ((bus.cpu_addr & OFF_MASK) != '0) || (bus.cpu_be == '0);
  assign wr_done    = (state == WR) && write_q && !bus.avl_waitrequest;
  assign rd_release = (state == RD) && read_q && !bus.avl_waitrequest;
  assign rd_done    = (rd_release || (state == RD_WAIT)) && bus.avl_readdatavalid;

`ifdef AVL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;

  // Counting starts with the first strobe cycle, so the abort lands TIMEOUT_CYC cycles after it
  always_ff @(posedge iCLK) begin
    if (iRST || state == IDLE || (state == WR && !write_q) || (state == RD && !read_q))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYC - 1)) && !wr_done && !rd_done;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_next;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wdone_q  <= wdone_d;
      rvalid_q <= rvalid_d;
      write_q  <= write_d;
      read_q   <= read_d;
      if (load) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
        be_q    <= bus.cpu_be;
      end
      if (rd_done)
        rdata_q <= bus.avl_readdata;
    end
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept && !bad_req) state_next = bus.cpu_we ? WR : RD;
        WR:      if (wr_done) state_next = IDLE;
        RD:      if (rd_release) state_next = bus.avl_readdatavalid ? IDLE : RD_WAIT;
        RD_WAIT: if (bus.avl_readdatavalid) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; strobes rise one cycle after entering WR/RD
  always_comb begin
    ack_d    = accept;
    err_d    = (accept && bad_req) || timeout;
    load     = accept && !bad_req;
    wdone_d  = wr_done;
    rvalid_d = rd_done;
    write_d  = (state == WR) && !wr_done && !timeout;
    read_d   = (state == RD) && !rd_release && !timeout;
  end

  assign bus.cpu_ack        = ack_q;
  assign bus.cpu_err        = err_q;
  assign bus.cpu_wdone      = wdone_q;
  assign bus.cpu_rvalid     = rvalid_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.busy           = (state != IDLE);
  assign bus.avl_address    = addr_q;
  assign bus.avl_read       = read_q;
  assign bus.avl_write      = write_q;
  assign bus.avl_writedata  = wdata_q;
  assign bus.avl_byteenable = be_q;
endmodule

// File: tb/tb_avl_mm_bridge.sv
// Directed bench for avl_mm_bridge: cycle-by-cycle vector table plus multi-cycle sequences.
module tb_avl_mm_bridge;
`ifdef AVL_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  avl_mm_bridge_if #(.ADDR_W(28), .DATA_W(32)) bus ();

  avl_mm_bridge #(.ADDR_W(28), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  // {ack, err, wdone, rvalid, write, read, busy}
  logic [6:0] flags;
  assign flags = {bus.cpu_ack, bus.cpu_err, bus.cpu_wdone, bus.cpu_rvalid,
                  bus.avl_write, bus.avl_read, bus.busy};

  typedef struct {
    logic        req;
    logic        we;
    logic [27:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wt;
    logic        rdv;
    logic [31:0] rd_in;
    logic [6:0]  exp_flags;
    logic [27:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tv[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [27:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_be    = be;
    bus.cpu_wdata = wdata;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".flags"}, 64'(flags), 64'd0);
    chk({nm, ".addr"},  64'(bus.avl_address), 64'd0);
    chk({nm, ".wdata"}, 64'(bus.avl_writedata), 64'd0);
    chk({nm, ".be"},    64'(bus.avl_byteenable), 64'd0);
    chk({nm, ".rdata"}, 64'(bus.cpu_rdata), 64'd0);
  endtask

  initial begin
    int n_write, n_wdone, n_read, n_rv, hold_bad, since;
    logic [31:0] got;

    drive(1'b0, 1'b0, '0, '0, '0);
    bus.avl_waitrequest   = 1'b0;
    bus.avl_readdatavalid = 1'b0;
    bus.avl_readdata      = '0;

    //           req we addr      be      wdata         wt rdv rd_in        flags       addr      rdata
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0000000, 28'h00, 32'h0});
    tv.push_back('{1, 1, 28'h10, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0,        7'b1000001, 28'h10, 32'h0});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0000101, 28'h10, 32'h0});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0010000, 28'h10, 32'h0});
    tv.push_back('{1, 0, 28'h24, 4'hF, 32'h0,        0, 0, 32'h0,        7'b1000001, 28'h24, 32'h0});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0000011, 28'h24, 32'h0});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 1, 32'hCAFEF00D, 7'b0001000, 28'h24, 32'hCAFEF00D});
    tv.push_back('{1, 0, 28'h22, 4'hF, 32'h0,        0, 0, 32'h0,        7'b1100000, 28'h24, 32'hCAFEF00D});
    tv.push_back('{1, 0, 28'h22, 4'hF, 32'h0,        0, 0, 32'h0,        7'b0000000, 28'h24, 32'hCAFEF00D});
    tv.push_back('{1, 0, 28'h30, 4'h0, 32'h0,        0, 0, 32'h0,        7'b1100000, 28'h24, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 1, 32'h11111111, 7'b0000000, 28'h24, 32'hCAFEF00D});
    tv.push_back('{1, 1, 28'h40, 4'h3, 32'h0000ABCD, 1, 0, 32'h0,        7'b1000001, 28'h40, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        1, 0, 32'h0,        7'b0000101, 28'h40, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        1, 0, 32'h0,        7'b0000101, 28'h40, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        1, 1, 32'h22222222, 7'b0000101, 28'h40, 32'hCAFEF00D});
    tv.push_back('{1, 0, 28'h50, 4'hF, 32'h0,        0, 0, 32'h0,        7'b0010000, 28'h40, 32'hCAFEF00D});
    tv.push_back('{1, 0, 28'h50, 4'hF, 32'h0,        0, 0, 32'h0,        7'b1000001, 28'h50, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        1, 0, 32'h0,        7'b0000011, 28'h50, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0000001, 28'h50, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0000001, 28'h50, 32'hCAFEF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 1, 32'h0BADF00D, 7'b0001000, 28'h50, 32'h0BADF00D});
    tv.push_back('{0, 0, 28'h00, 4'h0, 32'h0,        0, 0, 32'h0,        7'b0000000, 28'h50, 32'h0BADF00D});

    step();
    step();
    chk_zero("reset");
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].req, tv[i].we, tv[i].addr, tv[i].be, tv[i].wdata);
      bus.avl_waitrequest   = tv[i].wt;
      bus.avl_readdatavalid = tv[i].rdv;
      bus.avl_readdata      = tv[i].rd_in;
      step();
      chk($sformatf("vec%0d.flags", i), 64'(flags), 64'(tv[i].exp_flags));
      chk($sformatf("vec%0d.addr", i),  64'(bus.avl_address), 64'(tv[i].exp_addr));
      chk($sformatf("vec%0d.rdata", i), 64'(bus.cpu_rdata), 64'(tv[i].exp_rdata));
    end
    bus.avl_readdatavalid = 1'b0;
    bus.avl_waitrequest   = 1'b0;

    // Write stalled for 5 strobe cycles: strobe and Avalon outputs held 6 cycles, one wdone
    drive(1'b1, 1'b1, 28'h10, 4'hF, 32'hDEADBEEF);
    step();
    chk("wrstall.ack", 64'(bus.cpu_ack), 64'd1);
    drive(1'b0, 1'b0, '0, '0, '0);
    bus.avl_waitrequest = 1'b1;
    n_write = 0; n_wdone = 0; hold_bad = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (bus.avl_write) begin
        n_write++;
        if (bus.avl_address !== 28'h10 || bus.avl_writedata !== 32'hDEADBEEF ||
            bus.avl_byteenable !== 4'hF || bus.avl_read !== 1'b0)
          hold_bad++;
      end
      if (bus.cpu_wdone) n_wdone++;
      bus.avl_waitrequest = (n_write < 6);
    end
    chk("wrstall.write_cycles", 64'(n_write), 64'd6);
    chk("wrstall.hold", 64'(hold_bad), 64'd0);
    chk("wrstall.wdone_count", 64'(n_wdone), 64'd1);
    bus.avl_waitrequest = 1'b0;

    // Read with readdatavalid 7 cycles after the strobe
    drive(1'b1, 1'b0, 28'h20, 4'hF, '0);
    step();
    chk("rdlat.ack", 64'(bus.cpu_ack), 64'd1);
    drive(1'b0, 1'b0, '0, '0, '0);
    n_read = 0; n_rv = 0; since = -1; got = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.avl_read) begin
        n_read++;
        if (since < 0) since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (bus.cpu_rvalid) begin
        n_rv++;
        got = bus.cpu_rdata;
      end
      bus.avl_readdatavalid = (since == 7);
      bus.avl_readdata      = (since == 7) ? 32'h12345678 : 32'h0;
    end
    chk("rdlat.read_cycles", 64'(n_read), 64'd1);
    chk("rdlat.rvalid_count", 64'(n_rv), 64'd1);
    chk("rdlat.rdata", 64'(got), 64'h12345678);
    chk("rdlat.rdata_hold", 64'(bus.cpu_rdata), 64'h12345678);

    // Reset while waiting for read data: everything clears, late data is dropped
    drive(1'b1, 1'b0, 28'h60, 4'hF, '0);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    chk("rstwait.in_rd_wait", 64'(flags), 64'b0000001);
    rst = 1'b1;
    step();
    chk_zero("rstwait");
    rst = 1'b0;
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = 32'h55AA55AA;
    n_rv = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.cpu_rvalid) n_rv++;
      bus.avl_readdatavalid = 1'b0;
    end
    chk("rstwait.late_rvalid", 64'(n_rv), 64'd0);
    chk("rstwait.rdata", 64'(bus.cpu_rdata), 64'd0);

`ifdef AVL_TIMEOUT_EN
    // Slave never responds: abort with cpu_err 16 cycles after the strobe rises
    drive(1'b1, 1'b1, 28'h70, 4'hF, 32'h1);
    bus.avl_waitrequest = 1'b1;
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    step();
    chk("timeout.strobe", 64'(bus.avl_write), 64'd1);
    since = -1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (bus.cpu_err && since < 0) since = c;
    end
    chk("timeout.err_cycle", 64'(since), 64'd16);
    chk("timeout.after", 64'(flags), 64'd0);
    bus.avl_waitrequest = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
